demux_1x2_reg: RTL and testbench
================================

Name: demux_1x2_reg

Overview:
- Registered 1-to-2 demultiplexer: the inverse of the team's 2x1 muxes. It steers one input word stream onto one of two output lanes.
- Lane selection comes from an external select (Select_in) or an internal round-robin pointer.
- Each lane has a one-entry output register with a valid/ready handshake, so a stalled lane backpressures the source.
- Sits downstream of a shared data source and fans it out to two consumers.

Parameters:
- WIDTH, 8, data word width in bits.
- CNT_W, 8, width of each per-lane saturating accept counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- A_in  input  WIDTH  input data word.
- valid_in  input  1  A_in holds a word.
- ready_out  output  1  block accepts A_in this cycle.
- Select_in  input  1  lane select when rr_mode=0 (0 selects lane 0, 1 selects lane 1).
- rr_mode  input  1  1 selects the round-robin pointer; 0 selects Select_in.
- Y0_out  output  WIDTH  lane 0 data register.
- Y0_valid  output  1  lane 0 holds a word.
- Y0_ready  input  1  lane 0 consumer takes the word.
- Y1_out  output  WIDTH  lane 1 data register.
- Y1_valid  output  1  lane 1 holds a word.
- Y1_ready  input  1  lane 1 consumer takes the word.
- rr_ptr_out  output  1  current round-robin pointer.
- cnt0_out  output  CNT_W  words accepted into lane 0, saturating.
- cnt1_out  output  CNT_W  words accepted into lane 1, saturating.

Behaviour:
- Reset (asynchronous, active-high): Y0_out=0, Y1_out=0, Y0_valid=0, Y1_valid=0, rr_ptr_out=0, cnt0_out=0, cnt1_out=0. While reset is high, ready_out=0.
- Target lane (combinational): tgt = rr_mode ? rr_ptr : Select_in.
- Ready (combinational): ready_out = ~Yt_valid | Yt_ready, where Yt is the target lane. There is no path from valid_in to ready_out.
- Accept: acc = valid_in & ready_out. On acc:
  - Yt_out <= A_in and Yt_valid <= 1 at the next edge (latency 1 cycle).
  - cntT increments unless it is at 2^CNT_W-1, where it holds.
- Drain: a lane with Yn_valid & Yn_ready and no accept into it this cycle clears Yn_valid next edge. Yn_out holds its last value.
- Simultaneous drain and accept on the same lane: Yn_valid stays 1, Yn_out takes the new word. This gives full throughput of 1 word/cycle per lane.
- Lane isolation: the non-target lane's data/valid change only through its own drain. A stall on the non-target lane never blocks the input.
- Round-robin pointer: toggles on each acc when rr_mode=1. It holds when rr_mode=0 and when no accept occurs.
- Mode switch: switching rr_mode mid-stream takes effect the same cycle. The pointer keeps its value across switches; no reset of the pointer.
- valid_in=1 with ready_out=0: the word is not taken and the pointer does not move. The source must hold A_in/valid_in stable.
- Reset asserted mid-transfer: in-flight words in the lane registers are discarded. Outputs go to their reset values immediately (asynchronous).
- Y*_out is never X after reset.

Decomposition:
- Shared package (demux_pkg): LANE0=1'b0, LANE1=1'b1, default WIDTH and CNT_W constants.
- One natural sub-module: demux_lane_reg. It holds one lane's data register, valid flag, handshake and saturating counter, and is instantiated twice. Its inputs are load/data/ready; its outputs are data/valid/cnt.
- The top level holds the target select, the ready_out mux and the round-robin pointer.

Test Plan:
1. Reset release, rr_mode=0, Select_in=0, A_in=8'h5A, valid_in=1, Y0_ready=0 -> Y0_out=5A and Y0_valid=1 one cycle after the accept edge. Y1_valid stays 0. ready_out drops to 0 while lane 0 is full.
2. rr_mode=1, send 8'h01..8'h04 back-to-back, both readies=1 -> lane 0 gets 01 and 03, lane 1 gets 02 and 04. ready_out=1 every cycle. rr_ptr_out ends at 0. cnt0_out=2, cnt1_out=2.
3. Lane 1 stalled (Y1_ready=0, Y1_valid=1), rr_mode=0, Select_in=0, stream 8'hAA -> accepted into lane 0 with no stall. Lane 1 data is unchanged.
4. Simultaneous drain and load on lane 0: Y0_valid=1, Y0_ready=1, new word 8'h77 -> Y0_valid stays 1 and Y0_out=77 next cycle, with no bubble.
5. CNT_W=2: accept 5 words into lane 0 -> cnt0_out saturates at 3 and holds.
6. Assert reset asynchronously between edges with both lanes valid -> all outputs go to 0 before the next clk edge. rr_ptr_out=0 after release.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants for the registered 1-to-2 demultiplexer.
// Lane encodings match Select_in and the round-robin pointer.
package demux_pkg;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 8;

endpackage

// File: rtl/demux_lane_reg.sv
// One output lane: single-entry data register with valid/ready handshake
// and a saturating count of words loaded into it.
module demux_lane_reg
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ready_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic [CNT_W-1:0] cnt_out
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;

    // A load in the same cycle as a drain wins, so the lane keeps valid high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else if (load) begin
            data_q  <= data_in;
            valid_q <= 1'b1;
            if (cnt_q != '1)
                cnt_q <= cnt_q + 1'b1;
        end else if (valid_q && ready_in) begin
            valid_q <= 1'b0;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign cnt_out   = cnt_q;

endmodule

// File: rtl/demux_1x2_reg.sv
// Registered 1-to-2 demultiplexer: steers the input stream onto one of two
// handshaked lanes chosen by Select_in or a round-robin pointer.
module demux_1x2_reg
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic             Select_in,
    input  logic             rr_mode,
    output logic [WIDTH-1:0] Y0_out,
    output logic             Y0_valid,
    input  logic             Y0_ready,
    output logic [WIDTH-1:0] Y1_out,
    output logic             Y1_valid,
    input  logic             Y1_ready,
    output logic             rr_ptr_out,
    output logic [CNT_W-1:0] cnt0_out,
    output logic [CNT_W-1:0] cnt1_out
);

    logic rr_ptr;
    logic tgt;
    logic tgt_valid;
    logic tgt_ready;
    logic acc;
    logic load0;
    logic load1;

    always_comb begin
        tgt       = rr_mode ? rr_ptr : Select_in;
        tgt_valid = (tgt == LANE1) ? Y1_valid : Y0_valid;
        tgt_ready = (tgt == LANE1) ? Y1_ready : Y0_ready;
        // Readiness depends only on the target lane, never on valid_in.
        ready_out = ~reset & (~tgt_valid | tgt_ready);
        acc       = valid_in & ready_out;
        load0     = acc & (tgt == LANE0);
        load1     = acc & (tgt == LANE1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_ptr <= LANE0;
        else if (acc && rr_mode)
            rr_ptr <= ~rr_ptr;
    end

    assign rr_ptr_out = rr_ptr;

    demux_lane_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lane0 (
        .clk       (clk),
        .reset     (reset),
        .load      (load0),
        .data_in   (A_in),
        .ready_in  (Y0_ready),
        .data_out  (Y0_out),
        .valid_out (Y0_valid),
        .cnt_out   (cnt0_out)
    );

    demux_lane_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lane1 (
        .clk       (clk),
        .reset     (reset),
        .load      (load1),
        .data_in   (A_in),
        .ready_in  (Y1_ready),
        .data_out  (Y1_out),
        .valid_out (Y1_valid),
        .cnt_out   (cnt1_out)
    );

endmodule

// File: tb/tb_demux_1x2_reg.sv
// Scoreboard bench for demux_1x2_reg: stimulus queues expected lane words,
// a negedge monitor pops them as each lane hands a word to its consumer.
module tb_demux_1x2_reg;

    logic       clk;
    logic       reset;
    logic [7:0] A_in;
    logic       valid_in;
    logic       ready_out;
    logic       Select_in;
    logic       rr_mode;
    logic [7:0] Y0_out;
    logic       Y0_valid;
    logic       Y0_ready;
    logic [7:0] Y1_out;
    logic       Y1_valid;
    logic       Y1_ready;
    logic       rr_ptr_out;
    logic [7:0] cnt0_out;
    logic [7:0] cnt1_out;

    // Second instance with narrow counters for saturation.
    logic       b_reset;
    logic [7:0] b_A_in;
    logic       b_valid_in;
    logic       b_ready_out;
    logic [7:0] b_Y0_out;
    logic       b_Y0_valid;
    logic [7:0] b_Y1_out;
    logic       b_Y1_valid;
    logic       b_rr_ptr;
    logic [1:0] b_cnt0;
    logic [1:0] b_cnt1;

    int n_tests = 0;
    int n_fail  = 0;
    int stalls;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] e0;
    logic [7:0] e1;

    demux_1x2_reg dut (
        .clk        (clk),
        .reset      (reset),
        .A_in       (A_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .Select_in  (Select_in),
        .rr_mode    (rr_mode),
        .Y0_out     (Y0_out),
        .Y0_valid   (Y0_valid),
        .Y0_ready   (Y0_ready),
        .Y1_out     (Y1_out),
        .Y1_valid   (Y1_valid),
        .Y1_ready   (Y1_ready),
        .rr_ptr_out (rr_ptr_out),
        .cnt0_out   (cnt0_out),
        .cnt1_out   (cnt1_out)
    );

    demux_1x2_reg #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk        (clk),
        .reset      (b_reset),
        .A_in       (b_A_in),
        .valid_in   (b_valid_in),
        .ready_out  (b_ready_out),
        .Select_in  (1'b0),
        .rr_mode    (1'b0),
        .Y0_out     (b_Y0_out),
        .Y0_valid   (b_Y0_valid),
        .Y0_ready   (1'b1),
        .Y1_out     (b_Y1_out),
        .Y1_valid   (b_Y1_valid),
        .Y1_ready   (1'b1),
        .rr_ptr_out (b_rr_ptr),
        .cnt0_out   (b_cnt0),
        .cnt1_out   (b_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each negedge with valid & ready is one transfer to a consumer.
    always @(negedge clk) begin
        if (!reset) begin
            if (Y0_valid && Y0_ready) begin
                if (q0.size() == 0) begin
                    check("lane0_unexpected_word", {24'h0, Y0_out}, 32'hFFFF_FFFF);
                end else begin
                    e0 = q0.pop_front();
                    check("lane0_word", {24'h0, Y0_out}, {24'h0, e0});
                end
            end
            if (Y1_valid && Y1_ready) begin
                if (q1.size() == 0) begin
                    check("lane1_unexpected_word", {24'h0, Y1_out}, 32'hFFFF_FFFF);
                end else begin
                    e1 = q1.pop_front();
                    check("lane1_word", {24'h0, Y1_out}, {24'h0, e1});
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge with valid_in still high.
    task automatic send(input logic [7:0] d, input int lane, output int waited);
        bit done;
        done   = 1'b0;
        waited = 0;
        A_in     = d;
        valid_in = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (ready_out) begin
                if (lane == 0) q0.push_back(d);
                else           q1.push_back(d);
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 20) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL send_timeout: got ready_out=0 for %0d cycles expected 1", waited);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; b_reset = 1'b1;
        A_in = '0; valid_in = 1'b0; Select_in = 1'b0; rr_mode = 1'b0;
        Y0_ready = 1'b0; Y1_ready = 1'b0;
        b_A_in = '0; b_valid_in = 1'b0;

        #3;
        check("rst_y0_out",   {24'h0, Y0_out}, 32'h0);
        check("rst_y0_valid", {31'h0, Y0_valid}, 32'h0);
        check("rst_y1_valid", {31'h0, Y1_valid}, 32'h0);
        check("rst_ready",    {31'h0, ready_out}, 32'h0);
        check("rst_cnt0",     {24'h0, cnt0_out}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0; b_reset = 1'b0;

        // 1: single word into lane 0, consumer stalled
        send(8'h5A, 0, stalls);
        valid_in = 1'b0;
        @(negedge clk);
        check("t1_y0_out",   {24'h0, Y0_out}, 32'h5A);
        check("t1_y0_valid", {31'h0, Y0_valid}, 32'h1);
        check("t1_y1_valid", {31'h0, Y1_valid}, 32'h0);
        check("t1_ready",    {31'h0, ready_out}, 32'h0);
        check("t1_cnt0",     {24'h0, cnt0_out}, 32'h1);
        @(posedge clk); #1;
        Y0_ready = 1'b1;
        @(negedge clk);

        // 2: round-robin, four back-to-back words
        do_reset();
        rr_mode = 1'b1; Y0_ready = 1'b1; Y1_ready = 1'b1;
        begin
            int total;
            total = 0;
            send(8'h01, 0, stalls); total += stalls;
            send(8'h02, 1, stalls); total += stalls;
            send(8'h03, 0, stalls); total += stalls;
            send(8'h04, 1, stalls); total += stalls;
            check("t2_stalls", total, 0);
        end
        valid_in = 1'b0;
        @(negedge clk);
        check("t2_rr_ptr", {31'h0, rr_ptr_out}, 32'h0);
        check("t2_cnt0",   {24'h0, cnt0_out}, 32'h2);
        check("t2_cnt1",   {24'h0, cnt1_out}, 32'h2);

        // 3: lane 1 stalled full, lane 0 traffic unaffected
        do_reset();
        rr_mode = 1'b0; Select_in = 1'b1; Y0_ready = 1'b1; Y1_ready = 1'b0;
        send(8'hB1, 1, stalls);
        Select_in = 1'b0;
        send(8'hAA, 0, stalls);
        check("t3_stalls", stalls, 0);
        valid_in = 1'b0;
        @(negedge clk);
        check("t3_y1_out",   {24'h0, Y1_out}, 32'hB1);
        check("t3_y1_valid", {31'h0, Y1_valid}, 32'h1);
        @(posedge clk); #1;
        Y1_ready = 1'b1;
        @(posedge clk); #1;
        check("t3_y1_drained", {31'h0, Y1_valid}, 32'h0);

        // 4: drain and reload lane 0 in the same cycle
        do_reset();
        Select_in = 1'b0; Y0_ready = 1'b0;
        send(8'h66, 0, stalls);
        Y0_ready = 1'b1;
        send(8'h77, 0, stalls);
        check("t4_stalls", stalls, 0);
        valid_in = 1'b0;
        @(negedge clk);
        check("t4_y0_valid", {31'h0, Y0_valid}, 32'h1);
        check("t4_y0_out",   {24'h0, Y0_out}, 32'h77);
        check("t4_cnt0",     {24'h0, cnt0_out}, 32'h2);

        // 6: async reset with both lanes full and pointer at 1
        do_reset();
        Y0_ready = 1'b0; Y1_ready = 1'b0; rr_mode = 1'b1;
        send(8'hC0, 0, stalls);
        rr_mode = 1'b0; Select_in = 1'b1;
        send(8'hC1, 1, stalls);
        valid_in = 1'b0;
        @(negedge clk);
        check("t6_rr_hold",  {31'h0, rr_ptr_out}, 32'h1);
        check("t6_y0_valid", {31'h0, Y0_valid}, 32'h1);
        check("t6_y1_out",   {24'h0, Y1_out}, 32'hC1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t6_y0_out",   {24'h0, Y0_out}, 32'h0);
        check("t6_y1_out0",  {24'h0, Y1_out}, 32'h0);
        check("t6_valids",   {30'h0, Y1_valid, Y0_valid}, 32'h0);
        check("t6_rr_ptr",   {31'h0, rr_ptr_out}, 32'h0);
        check("t6_cnts",     {16'h0, cnt1_out, cnt0_out}, 32'h0);
        check("t6_ready",    {31'h0, ready_out}, 32'h0);
        q0.delete();
        q1.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6_rr_after", {31'h0, rr_ptr_out}, 32'h0);

        // 5: two-bit counter saturates at 3
        @(posedge clk); #1;
        b_A_in = 8'h10; b_valid_in = 1'b1;
        @(negedge clk);
        check("t5_ready", {31'h0, b_ready_out}, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        check("t5_cnt_2", {30'h0, b_cnt0}, 32'h2);
        repeat (3) @(posedge clk);
        #1;
        check("t5_cnt_sat", {30'h0, b_cnt0}, 32'h3);
        @(posedge clk); #1;
        b_valid_in = 1'b0;
        check("t5_cnt_hold", {30'h0, b_cnt0}, 32'h3);
        check("t5_cnt1",     {30'h0, b_cnt1}, 32'h0);

        // Drain everything left and confirm the scoreboard emptied.
        Y0_ready = 1'b1; Y1_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("q0_empty", q0.size(), 0);
        check("q1_empty", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
